// File: rtl/mem_port_arbiter_if.sv
// Core fetch/data ports and memory-side bus of mem_port_arbiter.
// slave = arbiter view; master = core plus memory view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_funct3;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        core_stall;
  logic        mem_err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_ready, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, d_misalign,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be, core_stall, mem_err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_ready, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, d_misalign,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be, core_stall, mem_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the core's fetch and data ports.
// Optional mem_ready watchdog: define MEM_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned FETCH_STARVE_MAX = 4,
  parameter int unsigned TIMEOUT_CYCLES   = 64
) (
  input logic               Clk,
  input logic               Reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_cmd_t;

  localparam int SW = $clog2(FETCH_STARVE_MAX + 1);

  state_t      state_q, state_d;
  mem_cmd_t    cmd_q, cmd_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        mis_q, mis_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        grant_fetch, grant_data;
  logic        d_misaligned;
  logic [3:0]  d_be;
  logic [31:0] d_wdata_lanes;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext;
  logic        tmo_hit;

  // Byte enables, lane replication and alignment check for the data port.
  always_comb begin
    d_be          = 4'b1111;
    d_wdata_lanes = bus.d_wdata;
    d_misaligned  = 1'b0;
    unique case (bus.d_funct3[1:0])
      2'b00: begin
        d_be          = 4'b0001 << bus.d_addr[1:0];
        d_wdata_lanes = {4{bus.d_wdata[7:0]}};
      end
      2'b01: begin
        d_be          = 4'b0011 << bus.d_addr[1:0];
        d_wdata_lanes = {2{bus.d_wdata[15:0]}};
        d_misaligned  = bus.d_addr[0];
      end
      default: d_misaligned = (bus.d_addr[1:0] != 2'b00);
    endcase
  end

  // Lane select and extension use the size/offset latched at grant time.
  always_comb begin
    ld_byte = bus.mem_rdata[{lane_q, 3'b000} +: 8];
    ld_half = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    unique case (f3_q[1:0])
      2'b00:   load_ext = {{24{ld_byte[7] & ~f3_q[2]}}, ld_byte};
      2'b01:   load_ext = {{16{ld_half[15] & ~f3_q[2]}}, ld_half};
      default: load_ext = bus.mem_rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = '0;
    err_d = 1'b0;
    if (state_q != IDLE && !bus.mem_ready) begin
      tmo_d = tmo_q + TW'(1);
      err_d = tmo_hit;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign bus.mem_err = err_q;
`else
  assign tmo_hit     = 1'b0;
  assign bus.mem_err = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case leaves one unassigned and infers a latch.
    state_d     = state_q;
    cmd_d       = cmd_q;
    starve_d    = starve_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    mis_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;

    unique case (state_q)
      IDLE: begin
        grant_fetch = bus.if_req && (!bus.d_req || starve_q == SW'(FETCH_STARVE_MAX));
        grant_data  = bus.d_req && !grant_fetch;
        if (grant_fetch) begin
          state_d  = FETCH;
          starve_d = '0;
          cmd_d    = '{req: 1'b1, we: 1'b0, addr: bus.if_addr & 32'hFFFF_FFFC,
                       wdata: 32'h0, be: 4'b1111};
        end else if (grant_data) begin
          if (bus.if_req) starve_d = starve_q + SW'(1);
          if (d_misaligned) begin
            // Rejected without touching memory; the ack goes out next cycle.
            d_ack_d   = 1'b1;
            mis_d     = 1'b1;
            d_rdata_d = '0;
          end else begin
            state_d = DATA;
            f3_d    = bus.d_funct3;
            lane_d  = bus.d_addr[1:0];
            cmd_d   = '{req: 1'b1, we: bus.d_we, addr: bus.d_addr & 32'hFFFF_FFFC,
                        wdata: d_wdata_lanes, be: d_be};
          end
        end
      end
      FETCH, DATA: begin
        if (bus.mem_ready || tmo_hit) begin
          state_d = IDLE;
          cmd_d   = '0;
          if (state_q == FETCH) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_ready ? bus.mem_rdata : 32'h0;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = bus.mem_ready ? load_ext : 32'h0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state, including returned read data, is cleared asynchronously so an abandoned access leaves no ack or stale data.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      starve_q   <= '0;
      f3_q       <= '0;
      lane_q     <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      mis_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      starve_q   <= starve_d;
      f3_q       <= f3_d;
      lane_q     <= lane_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      mis_q      <= mis_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.mem_req    = cmd_q.req;
  assign bus.mem_we     = cmd_q.we;
  assign bus.mem_addr   = cmd_q.addr;
  assign bus.mem_wdata  = cmd_q.wdata;
  assign bus.mem_be     = cmd_q.be;
  assign bus.if_ack     = if_ack_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.d_ack      = d_ack_q;
  assign bus.d_misalign = mis_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.core_stall = Reset && (bus.if_req || bus.d_req) && !(if_ack_q || d_ack_q);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the RISC_V core's instruction-fetch port (Pc/Instruction) and data port (AluResult_Memory/WriteData_Memory/Memory_Write/funct3/ReadData_Memory).
- Sequences each access with a req/ready handshake and generates byte enables and load extension from funct3.
- Drives a core_stall that holds the pipeline while any access is outstanding.
- Sits between the RISC_V top and the memory model/SoC bus.

Parameters:
- FETCH_STARVE_MAX, 4, max consecutive data grants while a fetch waits; the next grant is forced to fetch.
- TIMEOUT_CYCLES, 64, mem_ready watchdog limit; used only with MEM_TIMEOUT_EN.

Ports:
- Clk  input  1  clock; all logic on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request.
- if_addr  input  32  fetch address (Pc); word-aligned.
- if_rdata  output  32  fetched instruction.
- if_ack  output  1  one-cycle pulse; if_rdata valid.
- d_req  input  1  data request.
- d_we  input  1  1 = store (Memory_Write).
- d_addr  input  32  data address (AluResult_Memory).
- d_wdata  input  32  store data, unshifted (WriteData_Memory).
- d_funct3  input  3  access size/sign (funct3).
- d_rdata  output  32  load data, aligned and sign/zero-extended.
- d_ack  output  1  one-cycle pulse; d_rdata valid / store done.
- d_misalign  output  1  one-cycle pulse; misaligned access rejected.
- mem_req  output  1  memory request; held until mem_ready.
- mem_we  output  1  write strobe.
- mem_addr  output  32  word address; bits [1:0] forced to 0.
- mem_wdata  output  32  byte-lane-shifted store data.
- mem_be  output  4  byte enables.
- mem_ready  input  1  memory completes the request this cycle.
- mem_rdata  input  32  read data, valid with mem_ready.
- core_stall  output  1  freezes the core pipeline.
- mem_err  output  1  one-cycle pulse; watchdog timeout (MEM_TIMEOUT_EN only).

Behaviour:
- Reset (Reset = 0, asynchronous): state IDLE. All outputs 0, including if_rdata and d_rdata. Starvation counter = 0.
- FSM states: IDLE, FETCH, DATA.
- IDLE, both requests present: grant DATA unless the starvation counter equals FETCH_STARVE_MAX, in which case grant FETCH.
- IDLE, one request present: grant that request.
- Grant timing: mem_req and the address/controls are registered, so they are asserted the cycle after the grant decision.
- Request hold: mem_req, mem_addr, mem_we, mem_be and mem_wdata stay stable until the cycle mem_ready = 1.
- Completion on the cycle mem_ready = 1:
  - Capture mem_rdata.
  - Next cycle: pulse if_ack or d_ack, drive the corresponding rdata, return to IDLE.
- Back-to-back: a new grant is taken in the same cycle the ack is pulsed. Minimum access = 2 cycles with zero-wait memory.
- Starvation counter: increments on each DATA grant made while if_req = 1. Clears on any FETCH grant.
- core_stall = (if_req or d_req) and not the current ack. It is combinational from registered state.
- Byte enables and store alignment from d_funct3[1:0] and d_addr[1:0]:
  - Byte (00): be = 0001 << a. wdata replicated across all four lanes.
  - Half (01): be = 0011 << a, with a in {0, 2}. wdata half replicated.
  - Word (10): be = 1111, with a = 0.
- Misaligned access: half with a[0] = 1, or word with a != 0.
  - No mem_req is issued.
  - d_misalign and d_ack pulse together one cycle after the grant; d_rdata = 0.
- Load extension: select the addressed lane, then sign-extend when d_funct3[2] = 0, else zero-extend. Funct3 = 011, 110 and 111 are treated as word accesses.
- Fetch: be = 1111, mem_we = 0.
- Request changes mid-access: requests deasserted while in service are ignored. The access completes and still acks.
- Reset mid-access: the access is abandoned immediately; no ack is issued.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- When defined: a counter runs while mem_req = 1 and mem_ready = 0. On reaching TIMEOUT_CYCLES:
  - drop mem_req;
  - pulse mem_err together with the pending ack, with rdata = 0;
  - return to IDLE.
- When undefined: no counter, mem_err is tied to 0, and the block waits indefinitely for mem_ready.

Test Plan:
- Fetch only, if_addr = 0x100, mem_ready after 3 cycles with rdata 0x00500093 -> mem_addr = 0x100, be = 1111; if_ack pulses once with if_rdata = 0x00500093; core_stall = 0 on the ack cycle.
- Simultaneous if_req and d_req (load, addr 0x204, funct3 = 010), zero-wait memory -> data serviced first, then fetch; d_ack precedes if_ack by exactly 2 cycles.
- Store byte, d_addr = 0x203, wdata = 0x000000AB, funct3 = 000 -> mem_be = 1000, mem_wdata = 0xABABABAB, mem_we = 1, mem_addr = 0x200.
- LB / LBU at addr 0x301, mem_rdata = 0x0000F000 -> LB d_rdata = 0xFFFFFFF0; LBU d_rdata = 0x000000F0.
- Half load at addr 0x402 (funct3 = 001) -> mem_req issued with be = 1100. Word load at addr 0x402 (funct3 = 010) -> d_misalign = 1, no mem_req.
- Continuous d_req with if_req held, FETCH_STARVE_MAX = 4 -> 4 data grants, then a forced fetch grant.
- MEM_TIMEOUT_EN defined, mem_ready never asserted -> mem_err and d_ack pulse together 64 cycles after mem_req rises.
- Reset pulsed low mid-access -> all outputs return to 0 with no ack.
